// File: rtl/alu_scheduler_pkg.sv
// Shared definitions for the ALU scheduler: opcode mnemonics, sequencer state
// and sizing constants.
package alu_scheduler_pkg;

   localparam int OP_W           = 3;
   localparam int SHIFT_PASS_MAX = 8;

   typedef enum logic [OP_W-1:0] {
      ADD = 3'd0,
      SUB = 3'd1,
      AND = 3'd2,
      OR  = 3'd3,
      XOR = 3'd4,
      LSL = 3'd5,
      LSR = 3'd6,
      SEQ = 3'd7
   } op_mne;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } sched_state_t;

   function automatic logic is_shift(input logic [OP_W-1:0] op);
      return (op == LSL) || (op == LSR);
   endfunction

endpackage

// File: rtl/alu_scheduler_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie
// and flips to the other side after every accepted grant.
module rr_arb2 (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant,
   output logic       ptr
);

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = ptr ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         ptr <= 1'b0;
      else if (advance)
         ptr <= grant[0];
   end

endmodule

// File: rtl/alu_scheduler.sv
// Arbitrating sequencer in front of the shared ALU; shifts run as repeated
// single-bit passes. Optional grant counters: ALU_SCHED_PERF_CNT_EN.
module alu_scheduler
   import alu_scheduler_pkg::*;
#(
   parameter int W     = SHIFT_PASS_MAX,
   parameter int Ops   = OP_W,
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Req0_Valid,
   output logic             Req0_Ready,
   input  logic [Ops-1:0]   Req0_Op,
   input  logic [W-1:0]     Req0_A,
   input  logic [W-1:0]     Req0_B,
   input  logic             Req1_Valid,
   output logic             Req1_Ready,
   input  logic [Ops-1:0]   Req1_Op,
   input  logic [W-1:0]     Req1_A,
   input  logic [W-1:0]     Req1_B,
   output logic             Rsp_Valid,
   input  logic             Rsp_Ready,
   output logic             Rsp_Id,
   output logic [W-1:0]     Rsp_Out,
   output logic             Rsp_Zero,
   output logic             Rsp_Parity,
   output logic             Rsp_Odd,
   output logic             Busy,
`ifdef ALU_SCHED_PERF_CNT_EN
   output logic [CNT_W-1:0] Perf_Grants0,
   output logic [CNT_W-1:0] Perf_Grants1,
`endif
   output logic [W-1:0]     Alu_A,
   output logic [W-1:0]     Alu_B,
   output logic [Ops-1:0]   Alu_Op,
   output logic             Alu_SC,
   input  logic [W-1:0]     Alu_Out,
   input  logic             Alu_Zero,
   input  logic             Alu_Parity,
   input  logic             Alu_Odd
);

   localparam int            CW        = $clog2(W + 1);
   localparam logic [W-1:0]  SHIFT_LIM = W'(W);

   sched_state_t   state_q, state_d;
   logic [1:0]     req_vld, grant;
   logic           accept, sel_id, last_pass, unused_ptr;
   logic [Ops-1:0] op_sel, op_q;
   logic [W-1:0]   a_sel, b_sel, alu_b_d, alu_b_q, opnd_q;
   logic [CW-1:0]  cnt_d, cnt_q;
   logic           id_q;

   assign req_vld = {Req1_Valid, Req0_Valid};

   rr_arb2 u_arb (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .req     (req_vld),
      .advance (accept),
      .grant   (grant),
      .ptr     (unused_ptr)
   );

   assign sel_id    = grant[1];
   assign op_sel    = sel_id ? Req1_Op : Req0_Op;
   assign a_sel     = sel_id ? Req1_A  : Req0_A;
   assign b_sel     = sel_id ? Req1_B  : Req0_B;
   assign accept    = |(req_vld & {Req1_Ready, Req0_Ready});
   assign last_pass = (cnt_q == CW'(1));

   // Shifts become B single-bit passes (capped at W); a zero shift is one identity pass.
   always_comb begin
      cnt_d   = CW'(1);
      alu_b_d = b_sel;
      if (is_shift(op_sel)) begin
         if (b_sel == '0) begin
            alu_b_d = '0;
         end else begin
            alu_b_d = W'(1);
            cnt_d   = (b_sel >= SHIFT_LIM) ? CW'(W) : b_sel[CW-1:0];
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)    state_d = EXEC;
         EXEC:    if (last_pass) state_d = RESP;
         RESP:    if (Rsp_Ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      Req0_Ready = 1'b0;
      Req1_Ready = 1'b0;
      Rsp_Valid  = 1'b0;
      Busy       = 1'b1;
      case (state_q)
         IDLE: begin
            Req0_Ready = grant[0];
            Req1_Ready = grant[1];
            Busy       = 1'b0;
         end
         RESP:    Rsp_Valid = 1'b1;
         default: ;
      endcase
   end

   // Pass counter and the held response channel.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         cnt_q      <= '0;
         Rsp_Id     <= 1'b0;
         Rsp_Out    <= '0;
         Rsp_Zero   <= 1'b0;
         Rsp_Parity <= 1'b0;
         Rsp_Odd    <= 1'b0;
      end else if (accept) begin
         cnt_q <= cnt_d;
      end else if (state_q == EXEC) begin
         cnt_q <= cnt_q - CW'(1);
         if (last_pass) begin
            Rsp_Id     <= id_q;
            Rsp_Out    <= Alu_Out;
            Rsp_Zero   <= Alu_Zero;
            Rsp_Parity <= Alu_Parity;
            Rsp_Odd    <= Alu_Odd;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (accept) begin
         op_q    <= op_sel;
         opnd_q  <= a_sel;
         alu_b_q <= alu_b_d;
         id_q    <= sel_id;
      end else if (state_q == EXEC) begin
         opnd_q  <= Alu_Out;
      end
   end

   assign Alu_A  = opnd_q;
   assign Alu_B  = alu_b_q;
   assign Alu_Op = op_q;
   assign Alu_SC = 1'b0;

`ifdef ALU_SCHED_PERF_CNT_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Perf_Grants0 <= '0;
         Perf_Grants1 <= '0;
      end else if (accept) begin
         if (grant[0]) Perf_Grants0 <= sat_inc(Perf_Grants0);
         if (grant[1]) Perf_Grants1 <= sat_inc(Perf_Grants1);
      end
   end
`else
   localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler with a behavioural ALU attached to its ALU port.
module tb_alu_scheduler;
   import alu_scheduler_pkg::*;

   localparam int W = 8, Ops = 3, CNT_W = 16;

   logic           Clk = 1'b0, Reset_n = 1'b1;
   logic           Req0_Valid, Req0_Ready, Req1_Valid, Req1_Ready;
   logic [Ops-1:0] Req0_Op, Req1_Op, Alu_Op;
   logic [W-1:0]   Req0_A, Req0_B, Req1_A, Req1_B, Rsp_Out, Alu_A, Alu_B, Alu_Out;
   logic           Rsp_Valid, Rsp_Ready, Rsp_Id, Rsp_Zero, Rsp_Parity, Rsp_Odd, Busy;
   logic           Alu_SC, Alu_Zero, Alu_Parity, Alu_Odd;
`ifdef ALU_SCHED_PERF_CNT_EN
   logic [CNT_W-1:0] Perf_Grants0, Perf_Grants1;
`endif
   int n_tests = 0, n_fail = 0;

   always #5 Clk = ~Clk;

   alu_scheduler #(.W(W), .Ops(Ops), .CNT_W(CNT_W)) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .Req0_Valid(Req0_Valid), .Req0_Ready(Req0_Ready), .Req0_Op(Req0_Op), .Req0_A(Req0_A), .Req0_B(Req0_B),
      .Req1_Valid(Req1_Valid), .Req1_Ready(Req1_Ready), .Req1_Op(Req1_Op), .Req1_A(Req1_A), .Req1_B(Req1_B),
      .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_Id(Rsp_Id), .Rsp_Out(Rsp_Out),
      .Rsp_Zero(Rsp_Zero), .Rsp_Parity(Rsp_Parity), .Rsp_Odd(Rsp_Odd), .Busy(Busy),
`ifdef ALU_SCHED_PERF_CNT_EN
      .Perf_Grants0(Perf_Grants0), .Perf_Grants1(Perf_Grants1),
`endif
      .Alu_A(Alu_A), .Alu_B(Alu_B), .Alu_Op(Alu_Op), .Alu_SC(Alu_SC),
      .Alu_Out(Alu_Out), .Alu_Zero(Alu_Zero), .Alu_Parity(Alu_Parity), .Alu_Odd(Alu_Odd)
   );

   // Reference ALU: shifts move by Alu_B, SEQ returns 1 on equality.
   always_comb begin
      Alu_Out = '0;
      case (Alu_Op)
         ADD: Alu_Out = Alu_A + Alu_B;
         SUB: Alu_Out = Alu_A - Alu_B;
         AND: Alu_Out = Alu_A & Alu_B;
         OR:  Alu_Out = Alu_A | Alu_B;
         XOR: Alu_Out = Alu_A ^ Alu_B;
         LSL: Alu_Out = Alu_A << Alu_B;
         LSR: Alu_Out = Alu_A >> Alu_B;
         SEQ: Alu_Out = {7'd0, Alu_A == Alu_B};
         default: Alu_Out = '0;
      endcase
      Alu_Zero   = (Alu_Out == '0);
      Alu_Parity = ^Alu_Out;
      Alu_Odd    = Alu_Out[0];
   end

   task automatic issue(input bit id, input op_mne op, input logic [W-1:0] a, input logic [W-1:0] b);
      if (id) begin Req1_Valid = 1'b1; Req1_Op = op; Req1_A = a; Req1_B = b; end
      else    begin Req0_Valid = 1'b1; Req0_Op = op; Req0_A = a; Req0_B = b; end
      @(posedge Clk); #1;
      Req0_Valid = 1'b0;
      Req1_Valid = 1'b0;
   endtask

   task automatic wait_rsp(output int cycles);
      cycles = 0;
      while (!Rsp_Valid && cycles < 50) begin
         @(posedge Clk); #1;
         cycles++;
      end
   endtask

   task automatic consume();
      Rsp_Ready = 1'b1;
      @(posedge Clk); #1;
      Rsp_Ready = 1'b0;
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      n_tests++; if (Rsp_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", Rsp_Valid); end
      n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
      n_tests++; if (Rsp_Out !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_out: got %h want 00", Rsp_Out); end
      n_tests++; if ({Rsp_Id, Rsp_Zero, Rsp_Parity, Rsp_Odd} !== 4'b0) begin n_fail++; $display("FAIL reset_rsp_flags: got %b want 0000", {Rsp_Id, Rsp_Zero, Rsp_Parity, Rsp_Odd}); end
      n_tests++; if (Alu_SC !== 1'b0) begin n_fail++; $display("FAIL alu_sc: got %b want 0", Alu_SC); end
`ifdef ALU_SCHED_PERF_CNT_EN
      n_tests++; if ({Perf_Grants0, Perf_Grants1} !== '0) begin n_fail++; $display("FAIL reset_perf: got %h/%h want 0/0", Perf_Grants0, Perf_Grants1); end
`endif
      Reset_n = 1'b1;
   endtask

   task automatic test_single_op();
      int c;
      Req0_Valid = 1'b1; Req0_Op = ADD; Req0_A = 8'h12; Req0_B = 8'h34;
      #1;
      n_tests++; if ({Req1_Ready, Req0_Ready} !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b want 01", {Req1_Ready, Req0_Ready}); end
      @(posedge Clk); #1;
      Req0_Valid = 1'b0;
      n_tests++; if (Busy !== 1'b1 || Req0_Ready !== 1'b0) begin n_fail++; $display("FAIL single_busy: got busy=%b rdy=%b want 1/0", Busy, Req0_Ready); end
      wait_rsp(c);
      n_tests++; if (c != 1) begin n_fail++; $display("FAIL single_latency: got %0d want 1", c); end
      n_tests++; if (Rsp_Out !== 8'h46) begin n_fail++; $display("FAIL single_out: got %h want 46", Rsp_Out); end
      n_tests++; if (Rsp_Id !== 1'b0) begin n_fail++; $display("FAIL single_id: got %b want 0", Rsp_Id); end
      n_tests++; if ({Rsp_Zero, Rsp_Parity, Rsp_Odd} !== 3'b010) begin n_fail++; $display("FAIL single_flags: got %b want 010", {Rsp_Zero, Rsp_Parity, Rsp_Odd}); end
      consume();
      n_tests++; if (Rsp_Valid !== 1'b0 || Busy !== 1'b0) begin n_fail++; $display("FAIL single_release: got valid=%b busy=%b want 0/0", Rsp_Valid, Busy); end
   endtask

   task automatic test_shift();
      int c;
      issue(1'b1, LSL, 8'h03, 8'd3);
      wait_rsp(c);
      n_tests++; if (c != 3) begin n_fail++; $display("FAIL lsl3_passes: got %0d want 3", c); end
      n_tests++; if (Rsp_Out !== 8'h18) begin n_fail++; $display("FAIL lsl3_out: got %h want 18", Rsp_Out); end
      n_tests++; if (Rsp_Id !== 1'b1) begin n_fail++; $display("FAIL lsl3_id: got %b want 1", Rsp_Id); end
      consume();
      issue(1'b0, LSR, 8'hF0, 8'd9);
      wait_rsp(c);
      n_tests++; if (c != 8) begin n_fail++; $display("FAIL lsr9_passes: got %0d want 8", c); end
      n_tests++; if (Rsp_Out !== 8'h00) begin n_fail++; $display("FAIL lsr9_out: got %h want 00", Rsp_Out); end
      n_tests++; if (Rsp_Zero !== 1'b1) begin n_fail++; $display("FAIL lsr9_zero: got %b want 1", Rsp_Zero); end
      consume();
   endtask

   task automatic test_shift_zero_seq();
      int c;
      issue(1'b0, LSR, 8'hA5, 8'd0);
      wait_rsp(c);
      n_tests++; if (c != 1) begin n_fail++; $display("FAIL lsr0_passes: got %0d want 1", c); end
      n_tests++; if (Rsp_Out !== 8'hA5) begin n_fail++; $display("FAIL lsr0_out: got %h want a5", Rsp_Out); end
      consume();
      issue(1'b1, SEQ, 8'h7E, 8'h7E);
      wait_rsp(c);
      n_tests++; if (c != 1) begin n_fail++; $display("FAIL seq_passes: got %0d want 1", c); end
      n_tests++; if (Rsp_Out !== 8'h01 || Rsp_Odd !== 1'b1) begin n_fail++; $display("FAIL seq_out: got %h odd=%b want 01 odd=1", Rsp_Out, Rsp_Odd); end
      consume();
   endtask

   task automatic test_contention();
      int ng, nr, cyc;
      bit gseq[4];
      bit rseq[4];
      ng = 0; nr = 0; cyc = 0;
      Reset_n = 1'b0; #1; Reset_n = 1'b1;
      Rsp_Ready = 1'b1;
      Req0_Valid = 1'b1; Req0_Op = ADD; Req0_A = 8'h01; Req0_B = 8'h01;
      Req1_Valid = 1'b1; Req1_Op = ADD; Req1_A = 8'h10; Req1_B = 8'h10;
      #1;
      while ((ng < 4 || nr < 4) && cyc < 40) begin
         n_tests++; if (Req0_Ready && Req1_Ready) begin n_fail++; $display("FAIL both_ready: got 11 want at most one"); end
         if (Busy) begin
            n_tests++; if (Req0_Ready || Req1_Ready) begin n_fail++; $display("FAIL ready_while_busy: got %b want 00", {Req1_Ready, Req0_Ready}); end
         end
         if ((Req0_Ready || Req1_Ready) && ng < 4) begin gseq[ng] = Req1_Ready; ng++; end
         if (Rsp_Valid && nr < 4) begin
            rseq[nr] = Rsp_Id;
            n_tests++; if (Rsp_Out !== (Rsp_Id ? 8'h20 : 8'h02)) begin n_fail++; $display("FAIL cont_out: got %h for id %b", Rsp_Out, Rsp_Id); end
            nr++;
         end
         @(posedge Clk); #1;
         cyc++;
      end
      n_tests++; if (ng != 4 || nr != 4) begin n_fail++; $display("FAIL cont_timeout: got grants=%0d rsps=%0d want 4/4", ng, nr); end
      for (int k = 0; k < 4; k++) begin
         n_tests++; if (gseq[k] !== bit'(k % 2)) begin n_fail++; $display("FAIL cont_grant%0d: got %b want %b", k, gseq[k], bit'(k % 2)); end
         n_tests++; if (rseq[k] !== bit'(k % 2)) begin n_fail++; $display("FAIL cont_rsp_id%0d: got %b want %b", k, rseq[k], bit'(k % 2)); end
      end
      Req0_Valid = 1'b0; Req1_Valid = 1'b0;
      cyc = 0;
      while (Busy && cyc < 20) begin @(posedge Clk); #1; cyc++; end
      n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL cont_drain: got busy=%b want 0", Busy); end
      Rsp_Ready = 1'b0;
   endtask

   task automatic test_back_pressure();
      int c;
      issue(1'b0, ADD, 8'h20, 8'h05);
      wait_rsp(c);
      n_tests++; if (c != 1) begin n_fail++; $display("FAIL bp_latency: got %0d want 1", c); end
      Req1_Valid = 1'b1; Req1_Op = XOR; Req1_A = 8'h0F; Req1_B = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_tests++;
         if (Rsp_Valid !== 1'b1 || Rsp_Out !== 8'h25 || Rsp_Id !== 1'b0 || {Req1_Ready, Req0_Ready} !== 2'b00) begin
            n_fail++; $display("FAIL bp_hold%0d: got v=%b out=%h id=%b rdy=%b want 1/25/0/00", i, Rsp_Valid, Rsp_Out, Rsp_Id, {Req1_Ready, Req0_Ready});
         end
         @(posedge Clk);
      end
      #1;
      Rsp_Ready = 1'b1;
      @(posedge Clk); #1;
      Rsp_Ready = 1'b0;
      n_tests++; if (Rsp_Valid !== 1'b0 || Req1_Ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got v=%b rdy1=%b want 0/1", Rsp_Valid, Req1_Ready); end
      @(posedge Clk); #1;
      Req1_Valid = 1'b0;
      n_tests++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL bp_next_accept: got busy=%b want 1", Busy); end
      wait_rsp(c);
      n_tests++; if (Rsp_Out !== 8'hF0 || Rsp_Id !== 1'b1) begin n_fail++; $display("FAIL bp_next_out: got %h id=%b want f0 id=1", Rsp_Out, Rsp_Id); end
      consume();
   endtask

   task automatic test_reset_mid_op();
      int c;
      issue(1'b0, LSL, 8'h01, 8'd6);
      repeat (3) begin @(posedge Clk); #1; end
      n_tests++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b want 1", Busy); end
      Reset_n = 1'b0;
      #1;
      n_tests++; if (Rsp_Valid !== 1'b0 || Busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got v=%b busy=%b want 0/0", Rsp_Valid, Busy); end
`ifdef ALU_SCHED_PERF_CNT_EN
      n_tests++; if ({Perf_Grants0, Perf_Grants1} !== '0) begin n_fail++; $display("FAIL mid_perf: got %h/%h want 0/0", Perf_Grants0, Perf_Grants1); end
`endif
      Req0_Valid = 1'b1; Req0_Op = ADD; Req0_A = 8'h01; Req0_B = 8'h02;
      Req1_Valid = 1'b1; Req1_Op = ADD; Req1_A = 8'h05; Req1_B = 8'h05;
      #1;
      Reset_n = 1'b1;
      #1;
      n_tests++; if ({Req1_Ready, Req0_Ready} !== 2'b01) begin n_fail++; $display("FAIL mid_ptr: got %b want 01", {Req1_Ready, Req0_Ready}); end
      @(posedge Clk); #1;
      Req0_Valid = 1'b0; Req1_Valid = 1'b0;
      wait_rsp(c);
      n_tests++; if (Rsp_Out !== 8'h03 || Rsp_Id !== 1'b0) begin n_fail++; $display("FAIL mid_next_rsp: got %h id=%b want 03 id=0", Rsp_Out, Rsp_Id); end
`ifdef ALU_SCHED_PERF_CNT_EN
      n_tests++; if (Perf_Grants0 !== 16'd1 || Perf_Grants1 !== 16'd0) begin n_fail++; $display("FAIL mid_perf_count: got %0d/%0d want 1/0", Perf_Grants0, Perf_Grants1); end
`endif
      consume();
   endtask

   initial begin
      Req0_Valid = 1'b0; Req0_Op = '0; Req0_A = '0; Req0_B = '0;
      Req1_Valid = 1'b0; Req1_Op = '0; Req1_A = '0; Req1_B = '0;
      Rsp_Ready  = 1'b0;
      #1;
      test_reset();
      @(posedge Clk); #1;
      test_single_op();
      test_shift();
      test_shift_zero_seq();
      test_contention();
      test_back_pressure();
      test_reset_mid_op();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
